// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and defaults for the key click path
package key_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } click_state_t;

  localparam int GAP_CYCLES_DEFAULT = 2500000;
  localparam int MAX_CLICKS_DEFAULT = 3;
  localparam int CNT_W_DEFAULT      = 2;

endpackage

// File: rtl/key_click_decoder_if.sv
// rtl/key_click_decoder_if.sv - press input and click event bundle
interface key_click_decoder_if
  import key_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             key_pulse;
  logic             busy;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_clicks;
  logic             evt_sat;

  // master: the decoder producing events; slave: the debouncer/consumer side
  modport master (
    input  key_pulse,
    output busy,
    output evt_valid,
    output evt_clicks,
    output evt_sat
  );

  modport slave (
    output key_pulse,
    input  busy,
    input  evt_valid,
    input  evt_clicks,
    input  evt_sat
  );

endinterface

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - rising-edge detector on a registered copy of din
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_prev <= 1'b0;
    end else begin
      din_prev <= din;
    end
  end

  assign rise = din & ~din_prev;

endmodule

// File: rtl/key_click_decoder.sv
// rtl/key_click_decoder.sv - groups debounced presses into click-count events
module key_click_decoder
  import key_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int MAX_CLICKS = MAX_CLICKS_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  key_click_decoder_if.master  bus
);

  localparam int               TW       = $clog2(GAP_CYCLES);
  localparam logic [TW-1:0]    TIMER_END = TW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLICKS);

  click_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TW-1:0]    timer, timer_n;
  logic             sat, sat_n;
  logic             evt_valid, evt_valid_n;
  logic [CNT_W-1:0] evt_clicks, evt_clicks_n;
  logic             evt_sat, evt_sat_n;
  logic             press;

  key_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.key_pulse),
    .rise (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      timer      <= '0;
      sat        <= 1'b0;
      evt_valid  <= 1'b0;
      evt_clicks <= '0;
      evt_sat    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      timer      <= timer_n;
      sat        <= sat_n;
      evt_valid  <= evt_valid_n;
      evt_clicks <= evt_clicks_n;
      evt_sat    <= evt_sat_n;
    end
  end

  // A press always beats a coincident timeout: the group stays open.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    timer_n      = timer;
    sat_n        = sat;
    evt_valid_n  = 1'b0;
    evt_clicks_n = evt_clicks;
    evt_sat_n    = evt_sat;
    case (state)
      IDLE: begin
        if (press) begin
          state_n = COLLECT;
          cnt_n   = CNT_W'(1);
          timer_n = '0;
          sat_n   = 1'b0;
        end
      end
      COLLECT: begin
        if (press) begin
          timer_n = '0;
          if (cnt < CNT_MAX) begin
            cnt_n = cnt + 1'b1;
          end else begin
            sat_n = 1'b1;
          end
        end else if (timer == TIMER_END) begin
          state_n      = IDLE;
          evt_valid_n  = 1'b1;
          evt_clicks_n = cnt;
          evt_sat_n    = sat;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy       = (state == COLLECT);
  assign bus.evt_valid  = evt_valid;
  assign bus.evt_clicks = evt_clicks;
  assign bus.evt_sat    = evt_sat;

endmodule
